// File: rtl/muldiv_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_issue_ctrl_pkg
// Description : Shared state encodings, bus widths and latency defaults for
//               the EX-stage multiply/divide issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_issue_ctrl_pkg;

    localparam int DOUBLE_REG_BUS_W = 64;
    localparam int REG_BUS_W        = 32;
    localparam int LAT_CNT_W        = 6;
    localparam int MUL_MAX_LAT_DEF  = 4;
    localparam int DIV_MAX_LAT_DEF  = 40;

    typedef logic [DOUBLE_REG_BUS_W-1:0] double_reg_bus_t;
    typedef logic [REG_BUS_W-1:0]        reg_bus_t;

    typedef enum logic [1:0] {
        MDC_IDLE     = 2'd0,
        MDC_BUSY_MUL = 2'd1,
        MDC_BUSY_DIV = 2'd2,
        MDC_DONE     = 2'd3
    } mdc_state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_issue_ctrl_if
// Description : EX-lane request, unit handshake and result bus of the
//               multiply/divide issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_issue_ctrl_if;
    import muldiv_issue_ctrl_pkg::*;

    logic            flush_i;
    logic            ex_stall_i;
    logic            req_valid_i;
    logic            req_is_div_i;
    logic            req_signed_i;
    reg_bus_t        opa_i;
    reg_bus_t        opb_i;
    logic            mult_ready_i;
    double_reg_bus_t mult_result_i;
    logic            div_ready_i;
    double_reg_bus_t div_result_i;
    logic            mult_start_o;
    logic            div_start_o;
    logic            unit_cancel_o;
    logic            signed_o;
    reg_bus_t        opdata1_o;
    reg_bus_t        opdata2_o;
    double_reg_bus_t result_o;
    logic            result_valid_o;
    logic            stallreq_o;
    logic            err_o;

    // Controller side
    modport slave (
        input  flush_i, ex_stall_i, req_valid_i, req_is_div_i, req_signed_i,
        input  opa_i, opb_i, mult_ready_i, mult_result_i, div_ready_i, div_result_i,
        output mult_start_o, div_start_o, unit_cancel_o, signed_o,
        output opdata1_o, opdata2_o, result_o, result_valid_o, stallreq_o, err_o
    );

    // Pipeline / execution-unit side
    modport master (
        output flush_i, ex_stall_i, req_valid_i, req_is_div_i, req_signed_i,
        output opa_i, opb_i, mult_ready_i, mult_result_i, div_ready_i, div_result_i,
        input  mult_start_o, div_start_o, unit_cancel_o, signed_o,
        input  opdata1_o, opdata2_o, result_o, result_valid_o, stallreq_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/muldiv_lat_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_lat_watchdog
// Description : Saturating latency counter with a sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_lat_watchdog
    import muldiv_issue_ctrl_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_start,
    input  wire logic                 i_run,
    input  wire logic [LAT_CNT_W-1:0] i_max_lat,
    output logic                      o_err
);

    logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic                 err_q, err_d;

    // Count equals cycles elapsed since the start pulse; a unit still busy
    // at MAX_LAT cycles overruns its budget on the following cycle.
    always_comb begin
        lat_cnt_d = lat_cnt_q;
        err_d     = err_q;
        if (i_start) begin
            lat_cnt_d = LAT_CNT_W'(1);
        end else if (i_run) begin
            lat_cnt_d = (&lat_cnt_q) ? lat_cnt_q : lat_cnt_q + LAT_CNT_W'(1);
            if (lat_cnt_q >= i_max_lat) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            lat_cnt_q <= lat_cnt_d;
            err_q     <= err_d;
        end
    end

    assign o_err = err_q;

endmodule
`default_nettype wire

// File: rtl/muldiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_issue_ctrl
// Description : Issues one mul/div from the EX lane to the shared units,
//               stalls while busy and holds the {hi,lo} result until EX moves.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_issue_ctrl
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int MUL_MAX_LAT = MUL_MAX_LAT_DEF,
    parameter int DIV_MAX_LAT = DIV_MAX_LAT_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst,
    muldiv_issue_ctrl_if.slave bus
);

    localparam logic [LAT_CNT_W-1:0] C_MUL_LIM = LAT_CNT_W'(MUL_MAX_LAT);
    localparam logic [LAT_CNT_W-1:0] C_DIV_LIM = LAT_CNT_W'(DIV_MAX_LAT);

    mdc_state_e      state_q, state_d;
    logic            signed_q, signed_d;
    reg_bus_t        opa_q, opa_d;
    reg_bus_t        opb_q, opb_d;
    double_reg_bus_t result_q, result_d;

    logic w_accept;
    logic w_div0;
    logic w_start;
    logic w_busy;
    logic w_ready_match;
    logic w_run;

    assign w_accept      = (state_q == MDC_IDLE) && bus.req_valid_i && !bus.flush_i;
    assign w_div0        = bus.req_is_div_i && (bus.opb_i == '0);
    assign w_start       = w_accept && !w_div0;
    assign w_busy        = (state_q == MDC_BUSY_MUL) || (state_q == MDC_BUSY_DIV);
    assign w_ready_match = ((state_q == MDC_BUSY_MUL) && bus.mult_ready_i) ||
                           ((state_q == MDC_BUSY_DIV) && bus.div_ready_i);
    assign w_run         = w_busy && !bus.flush_i && !w_ready_match;

    // Flush is tested first in every busy/done state so it beats a
    // same-cycle ready and any request seen while returning to IDLE.
    always_comb begin
        state_d  = state_q;
        signed_d = signed_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        case (state_q)
            MDC_IDLE: begin
                if (w_accept) begin
                    signed_d = bus.req_signed_i;
                    opa_d    = bus.opa_i;
                    opb_d    = bus.opb_i;
                    if (w_div0) begin
                        result_d = '0;
                        state_d  = MDC_DONE;
                    end else begin
                        state_d = bus.req_is_div_i ? MDC_BUSY_DIV : MDC_BUSY_MUL;
                    end
                end
            end
            MDC_BUSY_MUL: begin
                if (bus.flush_i) begin
                    state_d = MDC_IDLE;
                end else if (bus.mult_ready_i) begin
                    result_d = bus.mult_result_i;
                    state_d  = MDC_DONE;
                end
            end
            MDC_BUSY_DIV: begin
                if (bus.flush_i) begin
                    state_d = MDC_IDLE;
                end else if (bus.div_ready_i) begin
                    result_d = bus.div_result_i;
                    state_d  = MDC_DONE;
                end
            end
            MDC_DONE: begin
                if (bus.flush_i || !bus.ex_stall_i) begin
                    state_d = MDC_IDLE;
                end
            end
            default: state_d = MDC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MDC_IDLE;
            signed_q <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            signed_q <= signed_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

    muldiv_lat_watchdog u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_run     (w_run),
        .i_max_lat ((state_q == MDC_BUSY_DIV) ? C_DIV_LIM : C_MUL_LIM),
        .o_err     (bus.err_o)
    );

    // Start fires in the issue cycle, so operands bypass the latch there.
    assign bus.mult_start_o   = w_start && !bus.req_is_div_i;
    assign bus.div_start_o    = w_start && bus.req_is_div_i;
    assign bus.unit_cancel_o  = w_busy && bus.flush_i;
    assign bus.signed_o       = w_accept ? bus.req_signed_i : signed_q;
    assign bus.opdata1_o      = w_accept ? bus.opa_i : opa_q;
    assign bus.opdata2_o      = w_accept ? bus.opb_i : opb_q;
    assign bus.result_o       = result_q;
    assign bus.result_valid_o = (state_q == MDC_DONE);
    assign bus.stallreq_o     = w_accept || (w_busy && !bus.flush_i);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_issue_ctrl
// Description : Transaction-level randomized bench for muldiv_issue_ctrl with
//               arithmetic reference results and behavioural unit models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_issue_ctrl;

    localparam int C_MUL_MAX = 4;
    localparam int C_DIV_MAX = 40;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    muldiv_issue_ctrl_if bus ();

    muldiv_issue_ctrl #(
        .MUL_MAX_LAT (C_MUL_MAX),
        .DIV_MAX_LAT (C_DIV_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Architectural {hi,lo} result of a MIPS mult/multu/div/divu.
    function automatic logic [63:0] calc(input logic d, input logic s,
                                         input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (!d) return s ? 64'(sa * sb) : 64'(ua * ub);
        if (b == 32'd0) return 64'd0;
        if (s) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction

    task automatic drive_idle();
        bus.flush_i       = 1'b0;
        bus.ex_stall_i    = 1'b0;
        bus.req_valid_i   = 1'b0;
        bus.req_is_div_i  = 1'b0;
        bus.req_signed_i  = 1'b0;
        bus.opa_i         = '0;
        bus.opb_i         = '0;
        bus.mult_ready_i  = 1'b0;
        bus.mult_result_i = '0;
        bus.div_ready_i   = 1'b0;
        bus.div_result_i  = '0;
    endtask

    // One EX instruction: unit answers lat cycles after issue, EX is held
    // for 'hold' cycles once the result is presented, optional flush at
    // cycle flush_at (-1 = none). The wrong unit also pulses ready once.
    task automatic run_txn(input logic d, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input int lat, input int hold,
                           input int flush_at);
        logic        div0, fl;
        int          done_c, end_instr, last;
        int          n_stall, n_ms, n_ds, n_cancel, n_valid, n_bad, start_c;
        logic [63:0] exp_res, u_res, first_res;
        logic [31:0] u_a, u_b;
        logic        u_s;
        div0      = d && (b == 32'd0);
        fl        = (flush_at >= 0);
        done_c    = div0 ? 1 : lat + 1;
        end_instr = fl ? flush_at : done_c + hold;
        last      = (fl ? lat : done_c + hold) + 3;
        exp_res   = calc(d, s, a, b);
        {n_stall, n_ms, n_ds, n_cancel, n_valid, n_bad} = '0;
        start_c   = -1;
        u_res     = '0;
        first_res = '1;
        {u_a, u_b, u_s} = '0;
        for (int c = 0; c < last; c++) begin
            @(posedge clk);
            #1;
            bus.req_valid_i   = (c <= end_instr);
            bus.req_is_div_i  = d;
            bus.req_signed_i  = s;
            bus.opa_i         = a;
            bus.opb_i         = b;
            bus.flush_i       = (c == flush_at);
            bus.ex_stall_i    = !fl && (c >= done_c) && (c < done_c + hold);
            bus.mult_ready_i  = !div0 && (d ? (lat >= 2 && c == lat - 1) : (c == lat));
            bus.div_ready_i   = !div0 && (d ? (c == lat) : (lat >= 2 && c == lat - 1));
            bus.mult_result_i = d ? 64'hDEAD_BEEF_0BAD_F00D : u_res;
            bus.div_result_i  = d ? u_res : 64'hDEAD_BEEF_0BAD_F00D;
            @(negedge clk);
            if (bus.stallreq_o)    n_stall++;
            if (bus.unit_cancel_o) n_cancel++;
            if (bus.mult_start_o || bus.div_start_o) begin
                if (bus.mult_start_o) n_ms++;
                if (bus.div_start_o)  n_ds++;
                start_c = c;
                u_a = bus.opdata1_o;
                u_b = bus.opdata2_o;
                u_s = bus.signed_o;
                u_res = calc(bus.div_start_o, bus.signed_o, bus.opdata1_o, bus.opdata2_o);
            end
            if (bus.result_valid_o) begin
                if (n_valid == 0) first_res = bus.result_o;
                if (bus.result_o !== exp_res) n_bad++;
                n_valid++;
            end
        end
        check_eq("stall_cycles", 64'(n_stall), 64'(fl ? flush_at : done_c));
        check_eq("mult_starts", 64'(n_ms), 64'(d ? 0 : 1));
        check_eq("div_starts", 64'(n_ds), 64'((d && !div0) ? 1 : 0));
        check_eq("cancels", 64'(n_cancel), 64'(fl ? 1 : 0));
        check_eq("valid_cycles", 64'(n_valid), 64'(fl ? 0 : hold + 1));
        check_eq("result_unstable", 64'(n_bad), 64'd0);
        check_eq("err", 64'(bus.err_o), 64'd0);
        if (!fl) check_eq("result", first_res, exp_res);
        if (start_c >= 0) begin
            check_eq("start_cycle", 64'(start_c), 64'd0);
            check_eq("opdata1", 64'(u_a), 64'(a));
            check_eq("opdata2", 64'(u_b), 64'(b));
            check_eq("signed", 64'(u_s), 64'(s));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {bus.result_o}, 64'd0);
        check_eq(tag, {bus.opdata1_o, bus.opdata2_o}, 64'd0);
        check_eq(tag, 64'({bus.mult_start_o, bus.div_start_o, bus.unit_cancel_o,
                           bus.signed_o, bus.result_valid_o, bus.stallreq_o, bus.err_o}), 64'd0);
    endtask

    initial begin
        logic        d, s;
        logic [31:0] a, b;
        int          kind, lat, fat;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed cases
        run_txn(1'b0, 1'b1, 32'd3, 32'hFFFF_FFFE, 3, 0, -1);
        run_txn(1'b1, 1'b0, 32'd100, 32'd7, 33, 0, -1);
        run_txn(1'b1, 1'b1, 32'd1234, 32'd0, 1, 0, -1);
        run_txn(1'b1, 1'b0, 32'd999, 32'd3, 20, 0, 10);
        run_txn(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 3, -1);
        run_txn(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 5, 1, -1);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 3));
            s    = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom;
            if (b == 32'd0) b = 32'd1;
            fat  = -1;
            case (kind)
                0: begin d = 1'b0; lat = int'($urandom_range(1, C_MUL_MAX)); end
                1: begin d = 1'b1; lat = int'($urandom_range(1, C_DIV_MAX)); end
                2: begin d = 1'b1; b = 32'd0; lat = 1; end
                default: begin
                    d   = 1'($urandom_range(0, 1));
                    lat = int'($urandom_range(2, d ? C_DIV_MAX : C_MUL_MAX));
                    fat = int'($urandom_range(1, lat - 1));
                end
            endcase
            run_txn(d, s, a, b, lat, int'($urandom_range(0, 3)), fat);
        end

        // Divider never answers: overrun flag after DIV_MAX cycles, sticky
        @(posedge clk);
        #1;
        bus.req_valid_i  = 1'b1;
        bus.req_is_div_i = 1'b1;
        bus.req_signed_i = 1'b0;
        bus.opa_i        = 32'd50;
        bus.opb_i        = 32'd5;
        for (int c = 0; c <= 45; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            if (c == 40) check_eq("err_at_40", 64'(bus.err_o), 64'd0);
            if (c == 41) check_eq("err_at_41", 64'(bus.err_o), 64'd1);
            if (c == 45) begin
                check_eq("err_sticky", 64'(bus.err_o), 64'd1);
                check_eq("still_busy", 64'(bus.stallreq_o), 64'd1);
            end
        end

        // Reset while busy
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid_busy");

        run_txn(1'b0, 1'b0, 32'd6, 32'd7, 1, 0, -1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
